ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle execute-stage consumer of the ID/EX register bundle. Handles RV32M multiply, divide and remainder.
- Accepts one operation when the ID/EX outputs present a valid M-type instruction.
- Runs an iterative radix-2 datapath and raises busy_o, which stalls the PC, IF/ID and ID/EX registers.
- Returns a registered result plus destination register with a one-cycle done_o pulse, which the EX/MEM write mux selects.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active low; synchronous deassert handled at top level.
- valid_i  input  1  ID/EX holds an M-extension instruction.
- flush_i  input  1  synchronous abort from branch/hazard logic.
- op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  input  XLEN  operand A (ID/EX rdata1).
- rs2_i  input  XLEN  operand B (ID/EX rdata2).
- rd_i  input  RD_W  destination register.
- busy_o  output  1  stall request to upstream pipeline registers.
- done_o  output  1  result valid, one-cycle pulse.
- result_o  output  XLEN  registered result; held until the next done_o.
- rd_o  output  RD_W  destination of the result; held with result_o.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0.
  - Counter and internal registers are cleared.
- FSM states: IDLE, CALC, SIGN, DONE.
- Acceptance:
  - An operation is accepted on a rising edge where valid_i=1, flush_i=0 and state is IDLE or DONE.
  - On acceptance: latch op, rd, operand magnitudes and result sign; cnt=0.
  - Next state is CALC, or DONE directly for a special case.
- CALC: one step per edge, cnt 0..31.
  - Multiply: shift-add on unsigned magnitudes into a 2*XLEN product.
  - Divide: restoring shift-subtract on magnitudes.
  - The edge with cnt=31 moves to SIGN.
- SIGN: one edge.
  - Negate the product/quotient/remainder if required.
  - Select the output half: MUL takes low XLEN; MULH/MULHSU/MULHU take high XLEN.
  - Load result_o and rd_o; go to DONE.
- Latency: done_o is high for exactly the cycle following the 33rd rising edge after the accepting edge (32 CALC + 1 SIGN).
- DONE: done_o=1 for that cycle only. Next state is CALC/DONE if a new op is accepted, otherwise IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Remainder takes the sign of the dividend. Quotient is negative iff the operand signs differ.
- Special cases (no CALC/SIGN; DONE one edge after accept, i.e. latency 1):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- busy_o (combinational):
  - 1 when state is CALC or SIGN.
  - 1 when state is IDLE/DONE and valid_i=1 and flush_i=0 (acceptance cycle).
  - 0 otherwise, including the DONE cycle with no new op.
- flush_i=1:
  - Next edge forces IDLE, dropping any op in progress.
  - No done_o; result_o and rd_o keep their old values.
  - Has priority over valid_i.
- Reset mid-operation: immediate IDLE with all outputs zero; no done_o after release.
- Operands and op are sampled only at acceptance. Changes on rs1_i/rs2_i/op_i during CALC are ignored.

Decomposition:
- Shared package ex_pkg holds:
  - op encodings MD_MUL..MD_REMU;
  - the state enum IDLE/CALC/SIGN/DONE;
  - constants XLEN=32 and RD_W=5;
  - the overflow/div-by-zero result constants.
- One natural sub-module: md_sign_fix. It is combinational magnitude/negate logic and is instantiated for operand abs and result negation.
- FSM, counter and datapath registers stay in ex_muldiv_unit.

Test Plan:
- MUL rs1=7 rs2=0xFFFFFFFD rd=5 -> busy_o high from the accept cycle. done_o pulses one cycle after the 33rd edge with result_o=0xFFFFFFEB, rd_o=5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. Each case has done_o one edge after accept.
- Flush and reset mid-op:
  - flush_i pulse at CALC cnt=10 -> IDLE next edge, busy_o=0, no done_o, result_o unchanged.
  - rst_n low mid-CALC -> outputs 0 immediately (asynchronous), no done_o afterwards.
- Back-to-back: valid_i held with a second op (DIVU 9/3) during the DONE cycle -> first result seen; second op accepted on that edge; done_o again 33 edges later with result_o=3.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit.
//   - op encodings (MD_MUL..MD_REMU), matching the op_i field
//   - FSM state enum (IDLE/CALC/SIGN/DONE)
//   - datapath widths and the fixed results of the divide special cases
package ex_pkg;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Most negative signed value, the overflowing dividend.
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    // Quotient for a zero divisor (DIV and DIVU alike).
    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    // INT_MIN / -1 results.
    localparam logic [XLEN-1:0] OVF_QUOT  = INT_MIN;
    localparam logic [XLEN-1:0] OVF_REM   = {XLEN{1'b0}};

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// (neg_i = operand is signed and negative) and to apply the final sign to the
// product / quotient / remainder.
//   val_i : value in
//   neg_i : 1 = negate
//   val_o : val_i or -val_i
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    localparam logic [W-1:0] ONE = W'(1);

    assign val_o = neg_i ? (~val_i + ONE) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply / divide / remainder unit for the execute stage.
// Accepts one op from the ID/EX register, iterates a radix-2 datapath for
// XLEN cycles, applies the sign, then pulses done_o with a registered result.
//   clk, rst_n        : clock, async active-low reset
//   valid_i, flush_i  : M-type op present / abort
//   op_i, rs1_i, rs2_i, rd_i : operation, operands, destination
//   busy_o            : stall request for PC, IF/ID and ID/EX
//   done_o            : one-cycle result strobe
//   result_o, rd_o    : result and destination, held until the next done_o
module ex_muldiv_unit #(
    parameter int XLEN = ex_pkg::XLEN,
    parameter int RD_W = ex_pkg::RD_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [RD_W-1:0] rd_o
);

    import ex_pkg::*;

    localparam int CNT_W = $clog2(XLEN);

    md_state_e         state_q;
    md_op_e            op_q;
    logic [RD_W-1:0]   rd_q, rd_out_q;
    logic [XLEN-1:0]   b_q, res_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, done_q;

    // ---------------- acceptance-side decode ----------------
    md_op_e          op_in;
    logic            a_neg, b_neg, is_div_in, is_rem_in, res_neg_in;
    logic            div_zero, div_ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign op_in     = md_op_e'(op_i);
    assign a_neg     = (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & rs1_i[XLEN-1];
    assign b_neg     = (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) & rs2_i[XLEN-1];
    assign is_div_in = op_i[2];
    assign is_rem_in = op_i[2] & op_i[1];
    // Remainder follows the dividend; product and quotient follow the xor.
    assign res_neg_in = is_rem_in ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div_in && (rs2_i == '0);
    assign div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                      (rs1_i == INT_MIN) && (rs2_i == '1);
    assign special_res = div_zero ? (is_rem_in ? rs1_i : DIV0_QUOT)
                                  : (is_rem_in ? OVF_REM : OVF_QUOT);

    assign accept = valid_i && !flush_i && (state_q == IDLE || state_q == DONE);
    assign busy_o = (state_q == CALC) || (state_q == SIGN) || accept;

    md_sign_fix #(.W(XLEN)) u_abs_a (.val_i(rs1_i), .neg_i(a_neg), .val_o(a_mag));
    md_sign_fix #(.W(XLEN)) u_abs_b (.val_i(rs2_i), .neg_i(b_neg), .val_o(b_mag));

    // ---------------- iteration step ----------------
    // Multiply: acc = {partial high, multiplier low}; add b when the
    // multiplier LSB is set, then shift the whole pair right.
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] mul_step, div_step;
    // Divide: acc = {remainder, quotient/dividend}; shift left, trial
    // subtract on the XLEN+1-bit shifted remainder, quotient bit into LSB.
    logic [XLEN:0]   div_hi;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    assign div_hi   = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_hi >= {1'b0, b_q};
    assign div_sub  = div_hi[XLEN-1:0] - b_q;
    assign div_step = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                             : {acc_q[2*XLEN-2:0], 1'b0};

    assign acc_d = op_q[2] ? div_step : mul_step;

    // ---------------- sign / output select ----------------
    logic [2*XLEN-1:0] fix_in, fixed;
    logic [XLEN-1:0]   sign_res;

    assign fix_in = !op_q[2] ? acc_q
                  : op_q[1]  ? {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                             : {{XLEN{1'b0}}, acc_q[XLEN-1:0]};

    md_sign_fix #(.W(2*XLEN)) u_fix_res (.val_i(fix_in), .neg_i(neg_q), .val_o(fixed));

    assign sign_res = (op_q == MD_MUL || op_q[2]) ? fixed[XLEN-1:0]
                                                  : fixed[2*XLEN-1:XLEN];

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= MD_MUL;
            rd_q     <= '0;
            rd_out_q <= '0;
            b_q      <= '0;
            res_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (accept) begin
                            op_q  <= op_in;
                            rd_q  <= rd_i;
                            b_q   <= b_mag;
                            acc_q <= {{XLEN{1'b0}}, a_mag};
                            neg_q <= res_neg_in;
                            cnt_q <= '0;
                            if (div_zero || div_ovf) begin
                                res_q    <= special_res;
                                rd_out_q <= rd_i;
                                done_q   <= 1'b1;
                                state_q  <= DONE;
                            end else begin
                                state_q <= CALC;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN-1))
                            state_q <= SIGN;
                    end
                    SIGN: begin
                        res_q    <= sign_res;
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes the hand-computed
// result, rd and expected done cycle; an independent monitor pops and checks
// on every done_o.
module tb_ex_muldiv_unit;

    logic        clk, rst_n, valid_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    ex_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result %h rd %0d (cycle %0d)", result_o, rd_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                           DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    endtask

    // Complete an acceptance at the next edge; lat = edges after the
    // accepting edge at which done_o is seen (33 normal, 0 special case).
    task automatic accept_push(input logic [31:0] exp, input logic [4:0] rd,
                               input int lat, input bit push);
        @(posedge clk);
        #1;
        if (push) sb.push_back('{res: exp, rd: rd, cyc: cyc + lat});
        valid_i = 1'b0;
        // Operands are ignored after acceptance; scramble them.
        rs1_i = $urandom; rs2_i = $urandom; op_i = 3'($urandom); rd_i = 5'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input bit push);
        @(negedge clk);
        drive(op, a, b, rd);
        #1 chk("busy_accept", {31'd0, busy_o}, 32'd1);
        accept_push(exp, rd, lat, push);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout outstanding %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
        issue(op, a, b, rd, exp, lat, 1'b1);
        drain();
    endtask

    initial begin
        rst_n = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy",   {31'd0, busy_o}, 32'd0);
        chk("reset_done",   {31'd0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd",     {27'd0, rd_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Multiplies
        run(MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        // DONE cycle with no new op must not stall
        chk("busy_idle", {31'd0, busy_o}, 32'd0);
        run(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
        run(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
        run(MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);

        // Divides
        run(DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33);
        run(REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33);
        run(DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       33);
        run(REMU,   32'd100,      32'd7,        5'd13, 32'd2,        33);

        // Flush at CALC cnt=10: back to IDLE, outputs hold REMU result
        issue(DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_busy",   {31'd0, busy_o}, 32'd0);
        chk("flush_done",   {31'd0, done_o}, 32'd0);
        chk("flush_result", result_o, 32'd2);
        chk("flush_rd",     {27'd0, rd_o}, 32'd13);
        repeat (40) @(negedge clk);
        chk("flush_hold", result_o, 32'd2);

        // Special cases: done_o in the cycle after the accepting edge
        run(DIVU, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 0);
        run(REM,  32'd5,        32'd0,        5'd15, 32'd5,        0);
        run(DIV,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 0);
        run(REM,  32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        0);

        // Asynchronous reset mid-CALC
        issue(MULHU, 32'h12345678, 32'h9ABCDEF0, 5'd21, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   {31'd0, busy_o}, 32'd0);
        chk("rst_mid_done",   {31'd0, done_o}, 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        chk("rst_mid_rd",     {27'd0, rd_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_after_result", result_o, 32'd0);

        // Back-to-back: second op presented during the first op's DONE cycle
        issue(MUL, 32'd6, 32'd7, 5'd3, 32'd42, 33, 1'b1);
        begin
            int n = 0;
            while (!done_o && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (!done_o) begin
                checks++;
                errors++;
                $display("FAIL b2b_first_done timeout got 0 expected 1");
            end
        end
        drive(DIVU, 32'd9, 32'd3, 5'd4);
        #1 chk("b2b_busy", {31'd0, busy_o}, 32'd1);
        accept_push(32'd3, 5'd4, 33, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
